fft_stream_ctrl: RTL

- Hardware frame sequencer in front of the fft core. It replaces bench-driven loading, start and readout.
- Accepts an N-point complex sample stream over valid/ready, writes it into fft memory in bit-reversed mode, pulses start, and waits for busy to complete.
- Streams the N results out in natural bin order with backpressure, then rearms for the next frame.

---
 rtl/fft_stream_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fft_stream_ctrl.sv
// Frame sequencer in front of the fft core: streams one N-point frame into fft memory
// in bit-reversed mode, starts the core, then streams the N results out with backpressure.
module fft_stream_ctrl #(
  parameter int LOGN   = 12,
  parameter int DW     = 128,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic [LOGN-1:0] m_index,
  output logic            m_last,
  output logic            fft_sig,
  output logic            fft_we,
  output logic            fft_rev,
  output logic [31:0]     fft_addr,
  output logic [DW-1:0]   fft_din,
  input  logic [DW-1:0]   fft_dout,
  input  logic            fft_busy,
  output logic            err_len,
  output logic [15:0]     frame_cnt
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [LOGN-1:0] LAST_ADDR = '1;
  localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);

  localparam logic [2:0] S_LOAD    = 3'd0;
  localparam logic [2:0] S_PAD     = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  logic [2:0]      state;
  logic            armed;
  logic [LOGN-1:0] wcnt;
  logic [LOGN-1:0] rcnt;
  logic            rd_done;
  logic [LOGN-1:0] addr;

  // Read pipeline: one valid bit and one bin index per cycle of core latency.
  logic [RD_LAT-1:0] rd_v;
  logic [LOGN-1:0]   rd_idx [RD_LAT];

  // Output FIFO sized so every outstanding read always has a slot to land in.
  logic [DW-1:0]   fifo_data [DEPTH];
  logic [LOGN-1:0] fifo_idx  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   outstanding;

  logic load_beat;
  logic rd_issue;
  logic rd_land;
  logic pop;

  // armed holds s_ready low for the first cycle after reset releases.
  assign s_ready   = (state == S_LOAD) && armed;
  assign load_beat = s_valid && s_ready;
  assign m_valid   = (fifo_cnt != '0);
  assign pop       = m_valid && m_ready;
  assign rd_land   = rd_v[RD_LAT-1];
  // A slot freed by this cycle's pop may be claimed at once, which sustains 1 bin/cycle.
  assign rd_issue  = (state == S_DRAIN) && !rd_done && ((outstanding < DEPTH_C) || pop);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    fft_we  = 1'b0;
    fft_din = '0;
    err_len = 1'b0;
    addr    = '0;
    case (state)
      S_LOAD: begin
        addr = wcnt;
        if (load_beat) begin
          fft_we  = 1'b1;
          fft_din = s_data;
          err_len = (wcnt == LAST_ADDR) ? !s_last : s_last;
        end
      end
      S_PAD: begin
        addr   = wcnt;
        fft_we = 1'b1;
      end
      S_DRAIN: addr = rcnt;
      default: ;
    endcase
  end

  assign fft_rev  = fft_we;
  assign fft_sig  = (state == S_START);
  assign fft_addr = {{(32-LOGN){1'b0}}, addr};

  // FIFO storage is not reset, so the head is gated to keep outputs at 0 while empty.
  assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_index = m_valid ? fifo_idx[rd_ptr]  : '0;
  assign m_last  = m_valid && (fifo_idx[rd_ptr] == LAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      armed       <= 1'b0;
      wcnt        <= '0;
      rcnt        <= '0;
      rd_done     <= 1'b0;
      rd_v        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      frame_cnt   <= '0;
    end else begin
      armed       <= 1'b1;
      rd_v        <= (rd_v << 1) | RD_LAT'(rd_issue);
      fifo_cnt    <= fifo_cnt + CW'(rd_land) - CW'(pop);
      outstanding <= outstanding + CW'(rd_issue) - CW'(pop);
      if (rd_land) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

      case (state)
        S_LOAD: begin
          if (load_beat) begin
            wcnt <= wcnt + LOGN'(1);
            if (wcnt == LAST_ADDR) state <= S_START;
            else if (s_last)       state <= S_PAD;
          end
        end
        S_PAD: begin
          wcnt <= wcnt + LOGN'(1);
          if (wcnt == LAST_ADDR) state <= S_START;
        end
        S_START:   state <= S_WAIT_HI;
        S_WAIT_HI: if (fft_busy) state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!fft_busy) begin
            state   <= S_DRAIN;
            rcnt    <= '0;
            rd_done <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (rd_issue) begin
            rcnt <= rcnt + LOGN'(1);
            if (rcnt == LAST_ADDR) rd_done <= 1'b1;
          end
          if (pop && m_last) begin
            state     <= S_LOAD;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // NOTE: data-path storage carries no reset; validity is tracked by rd_v and fifo_cnt instead.
  always_ff @(posedge clk) begin
    rd_idx[0] <= rcnt;
    for (int i = 1; i < RD_LAT; i++) rd_idx[i] <= rd_idx[i-1];
    if (rd_land) begin
      fifo_data[wr_ptr] <= fft_dout;
      fifo_idx[wr_ptr]  <= rd_idx[RD_LAT-1];
    end
  end

endmodule
